// File: rtl/cordic_serial_addsub.sv
// Bit-serial a +/- (b >>> shift) for one CORDIC micro-rotation, one full-adder cell, LSB first.
// Optional feature: define CORDIC_SAT_EN to saturate the result on signed overflow.

module fa1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module cordic_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic [SHW-1:0]   shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam int IW = ((CW > SHW) ? CW : SHW) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sub_q;
    logic [SHW-1:0]   shift_q;
    logic             carry;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] result;
    logic             ovf_q;

    logic             accept;
    logic             last;
    logic [IW-1:0]    idx_sum;
    logic [CW-1:0]    b_idx;
    logic             abit;
    logic             bbit;
    logic             s_bit;
    logic             cout;
    logic [WIDTH-1:0] result_next;
    logic [WIDTH-1:0] sat_value;

    assign accept = in_valid && (state == IDLE);
    assign last   = (state == RUN) && (count == CW'(WIDTH - 1));

    // Indices past the MSB read the sign bit, which is exactly an arithmetic shift of b.
    always_comb begin
        idx_sum = IW'(count) + IW'(shift_q);
        if (idx_sum > IW'(WIDTH - 1))
            b_idx = CW'(WIDTH - 1);
        else
            b_idx = idx_sum[CW-1:0];
    end

    assign abit = a_q[count];
    assign bbit = b_q[b_idx] ^ sub_q;

    fa1bit u_fa (
        .a    (abit),
        .b    (bbit),
        .cin  (carry),
        .s    (s_bit),
        .cout (cout)
    );

    assign result_next = {s_bit, result[WIDTH-1:1]};
    assign sat_value   = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            shift_q <= '0;
            carry   <= 1'b0;
            count   <= '0;
            result  <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            shift_q <= shift;
            carry   <= sub;
            count   <= '0;
        end else if (state == RUN) begin
            carry <= cout;
            count <= count + CW'(1);
            if (last) begin
                // Signed overflow: carry into the MSB differs from carry out of it.
                ovf_q <= carry ^ cout;
`ifdef CORDIC_SAT_EN
                result <= (carry ^ cout) ? sat_value : result_next;
`else
                result <= result_next;
`endif
            end else begin
                result <= result_next;
            end
        end
    end

`ifndef CORDIC_SAT_EN
    logic unused_sat;
    assign unused_sat = ^sat_value;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = result;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cordic_serial_addsub.sv
// Randomised and directed checks of cordic_serial_addsub against an integer-arithmetic model.
// Follows CORDIC_SAT_EN the same way as the design.

module tb_cordic_serial_addsub;
    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [SHW-1:0]   shift;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    cordic_serial_addsub #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Returns {ovf, sum} from plain signed integer arithmetic.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                             input logic msub, input logic [SHW-1:0] msh);
        int sa;
        int sb;
        int r;
        int maxv;
        int minv;
        logic ov;
        logic [WIDTH-1:0] res;
        maxv = (1 << (WIDTH - 1)) - 1;
        minv = -(1 << (WIDTH - 1));
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        sb = sb >>> msh;
        r  = msub ? sa - sb : sa + sb;
        ov = (r > maxv) || (r < minv);
        res = r[WIDTH-1:0];
`ifdef CORDIC_SAT_EN
        if (ov) res = (sa >= 0) ? WIDTH'(maxv) : WIDTH'(minv);
`endif
        return {ov, res};
    endfunction

    // edges counts the accept edge as the first one.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tsub, input logic [SHW-1:0] tsh,
                          output int edges, output logic timeout);
        int g;
        a = ta; b = tb; sub = tsub; shift = tsh;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom);
        sub = 1'($urandom); shift = SHW'($urandom);
        edges = 1;
        while (!out_valid && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        timeout = !out_valid;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; shift = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (sum !== '0) begin errors++; $display("[TB] FAIL reset_sum: got %h expected 0000", sum); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [6] = '{16'd100, 16'd100, 16'hFFFB, 16'hFFFB, 16'h7FFF, 16'h8000};
        logic [WIDTH-1:0] vb [6] = '{16'd23,  16'd64,  16'hFFE0, 16'hFFE0, 16'h0001, 16'h0001};
        logic             vs [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [SHW-1:0]   vh [6] = '{4'd0, 4'd3, 4'd15, 4'd9, 4'd0, 4'd0};
        logic [WIDTH:0] exp;
        int edges;
        logic to;
        for (int i = 0; i < 6; i++) begin
            exp = model(va[i], vb[i], vs[i], vh[i]);
            run_op(va[i], vb[i], vs[i], vh[i], edges, to);
            checks++;
            if (to) begin errors++; $display("[TB] FAIL directed%0d_timeout: out_valid never rose", i); end
            checks++;
            if (edges != WIDTH + 1) begin errors++; $display("[TB] FAIL directed%0d_latency: got %0d edges expected %0d", i, edges, WIDTH + 1); end
            checks++;
            if (sum !== exp[WIDTH-1:0]) begin errors++; $display("[TB] FAIL directed%0d_sum: got %h expected %h", i, sum, exp[WIDTH-1:0]); end
            checks++;
            if (ovf !== exp[WIDTH]) begin errors++; $display("[TB] FAIL directed%0d_ovf: got %b expected %b", i, ovf, exp[WIDTH]); end
            consume();
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rs;
        logic [SHW-1:0]   rh;
        logic [WIDTH:0]   exp;
        int edges;
        int hold;
        logic to;
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom);
            rs = 1'($urandom); rh = SHW'($urandom);
            if (i % 4 == 0) begin
                ra = ($urandom_range(0, 1) == 1) ? 16'h7FF0 : 16'h8010;
                rh = SHW'($urandom_range(0, 2));
            end
            exp = model(ra, rb, rs, rh);
            run_op(ra, rb, rs, rh, edges, to);
            hold = $urandom_range(0, 3);
            repeat (hold) begin @(posedge clk); #1; end
            checks++;
            if (to || edges != WIDTH + 1) begin errors++; $display("[TB] FAIL random%0d_latency: got %0d edges expected %0d", i, edges, WIDTH + 1); end
            checks++;
            if (sum !== exp[WIDTH-1:0]) begin errors++; $display("[TB] FAIL random%0d_sum: a=%h b=%h sub=%b sh=%0d got %h expected %h", i, ra, rb, rs, rh, sum, exp[WIDTH-1:0]); end
            checks++;
            if (ovf !== exp[WIDTH]) begin errors++; $display("[TB] FAIL random%0d_ovf: got %b expected %b", i, ovf, exp[WIDTH]); end
            consume();
        end
    endtask

    task automatic test_hold();
        logic [WIDTH:0] exp;
        logic [WIDTH:0] exp2;
        int edges;
        logic to;
        exp  = model(16'h1234, 16'h0F00, 1'b1, 4'd2);
        exp2 = model(16'h0042, 16'hFF00, 1'b0, 4'd4);
        run_op(16'h1234, 16'h0F00, 1'b1, 4'd2, edges, to);
        in_valid = 1'b1; a = 16'h5555; b = 16'h2222; sub = 1'b0; shift = '0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold%0d_handshake: got out_valid=%b in_ready=%b expected 1/0", i, out_valid, in_ready); end
            checks++;
            if (sum !== exp[WIDTH-1:0] || ovf !== exp[WIDTH]) begin errors++; $display("[TB] FAIL hold%0d_sum: got %h/%b expected %h/%b", i, sum, ovf, exp[WIDTH-1:0], exp[WIDTH]); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        consume();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
        run_op(16'h0042, 16'hFF00, 1'b0, 4'd4, edges, to);
        checks++;
        if (to || sum !== exp2[WIDTH-1:0]) begin errors++; $display("[TB] FAIL hold_next_sum: got %h expected %h", sum, exp2[WIDTH-1:0]); end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH:0] e1;
        logic [WIDTH:0] e2;
        int t1;
        int t2;
        int g;
        logic seen1;
        e1 = model(16'h0ABC, 16'h1357, 1'b0, 4'd1);
        e2 = model(16'hF000, 16'h7FFF, 1'b1, 4'd0);
        out_ready = 1'b1;
        a = 16'h0ABC; b = 16'h1357; sub = 1'b0; shift = 4'd1;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        t1 = cyc;
        a = 16'hF000; b = 16'h7FFF; sub = 1'b1; shift = 4'd0;
        seen1 = 1'b0;
        g = 0;
        while (!in_ready && g < 100) begin
            if (out_valid) begin
                seen1 = 1'b1;
                checks++;
                if (sum !== e1[WIDTH-1:0]) begin errors++; $display("[TB] FAIL b2b_sum1: got %h expected %h", sum, e1[WIDTH-1:0]); end
            end
            @(posedge clk); #1;
            g++;
        end
        checks++;
        if (!seen1) begin errors++; $display("[TB] FAIL b2b_valid1: got no out_valid expected one"); end
        @(posedge clk); #1;
        t2 = cyc;
        in_valid = 1'b0;
        checks++;
        if (t2 - t1 != WIDTH + 2) begin errors++; $display("[TB] FAIL b2b_interval: got %0d expected %0d", t2 - t1, WIDTH + 2); end
        g = 0;
        while (!out_valid && g < 100) begin @(posedge clk); #1; g++; end
        checks++;
        if (!out_valid || sum !== e2[WIDTH-1:0] || ovf !== e2[WIDTH]) begin errors++; $display("[TB] FAIL b2b_sum2: got %h/%b expected %h/%b", sum, ovf, e2[WIDTH-1:0], e2[WIDTH]); end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        int edges;
        logic to;
        a = 16'h7FFF; b = 16'h1234; sub = 1'b0; shift = '0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || ovf !== 1'b0) begin errors++; $display("[TB] FAIL abort_clear: got out_valid=%b sum=%h ovf=%b expected 0/0000/0", out_valid, sum, ovf); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (WIDTH + 2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_no_result: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
        run_op(16'd1, 16'd2, 1'b0, 4'd0, edges, to);
        checks++;
        if (to || sum !== 16'd3 || ovf !== 1'b0) begin errors++; $display("[TB] FAIL abort_next_sum: got %h/%b expected 0003/0", sum, ovf); end
        consume();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
